// File: rtl/unary_mul_seq.sv
// Sequencer for a rate-coded (unary) multiplier: latches an operand pair, clears the
// Sobol generators for one cycle, then counts 1s on the product stream for 2^LOG_CYC cycles.
module unary_mul_seq #(
  parameter int WIDTH   = 16,
  parameter int LOG_CYC = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-2:0]   in_data_i,
  input  logic [WIDTH-2:0]   in_data_w,
  input  logic               abort,
  output logic               mul_clr_n,
  output logic [WIDTH-2:0]   mul_data_i,
  output logic [WIDTH-2:0]   mul_data_w,
  input  logic               mul_bit,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LOG_CYC:0]   out_count,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t             state;
  logic [LOG_CYC-1:0] cyc_cnt;
  logic [LOG_CYC:0]   acc;

  // Outputs are pure state decodes or registers; no input reaches an output combinationally.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_count = acc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cyc_cnt    <= '0;
      acc        <= '0;
      mul_data_i <= '0;
      mul_data_w <= '0;
      mul_clr_n  <= 1'b0;
    end else begin
      mul_clr_n <= 1'b1;
      case (state)
        IDLE: if (in_valid) begin
          mul_data_i <= in_data_i;
          mul_data_w <= in_data_w;
          mul_clr_n  <= 1'b0;
          state      <= CLEAR;
        end
        CLEAR: begin
          acc     <= '0;
          cyc_cnt <= '0;
          state   <= abort ? IDLE : RUN;
        end
        RUN: begin
          if (abort) begin
            acc     <= '0;
            cyc_cnt <= '0;
            state   <= IDLE;
          end else begin
            // Counter is exactly LOG_CYC bits, so it wraps to 0 on the last run cycle.
            acc     <= acc + {{LOG_CYC{1'b0}}, mul_bit};
            cyc_cnt <= cyc_cnt + {{(LOG_CYC-1){1'b0}}, 1'b1};
            if (&cyc_cnt) state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unary_mul_seq.sv
// Directed + randomized bench for unary_mul_seq; expected counts are the number of 1s
// the bench itself drove on mul_bit during the N run cycles of each job.
module tb_unary_mul_seq;
  localparam int WIDTH   = 16;
  localparam int LOG_CYC = 8;
  localparam int N       = 1 << LOG_CYC;

  logic               clk = 1'b0;
  logic               rst_n, in_valid, in_ready, abort, mul_clr_n, mul_bit;
  logic               out_valid, out_ready, busy;
  logic [WIDTH-2:0]   in_data_i, in_data_w, mul_data_i, mul_data_w;
  logic [LOG_CYC:0]   out_count;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  unary_mul_seq #(.WIDTH(WIDTH), .LOG_CYC(LOG_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data_i(in_data_i), .in_data_w(in_data_w), .abort(abort),
    .mul_clr_n(mul_clr_n), .mul_data_i(mul_data_i), .mul_data_w(mul_data_w),
    .mul_bit(mul_bit), .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pick_bit(input int mode, input int k);
    case (mode)
      0: return 1'b1;
      1: return 1'b0;
      2: return (k % 2 == 0);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Offer one operand pair, run it and check outcome. abort_at<0 means no abort;
  // rst_at>=0 pulses reset at that run cycle instead.
  task automatic run_job(input logic [WIDTH-2:0] di, input logic [WIDTH-2:0] dw,
                         input int mode, input int abort_at, input int rst_at, input int hold);
    int sum = 0;
    int wait_cnt = 0;
    logic b;
    while (!in_ready && wait_cnt < 20) begin step(); wait_cnt++; end
    chk("accept_ready", in_ready, 1);
    in_valid = 1'b1; in_data_i = di; in_data_w = dw;
    step();
    in_valid = 1'b0; in_data_i = $urandom; in_data_w = $urandom;
    chk("clear_clr_n", mul_clr_n, 0);
    chk("clear_busy", busy, 1);
    chk("clear_in_ready", in_ready, 0);
    chk("latch_i", mul_data_i, di);
    chk("latch_w", mul_data_w, dw);
    for (int k = 0; k < N; k++) begin
      step();
      b = pick_bit(mode, k);
      mul_bit = b;
      sum += int'(b);
      chk("run_clr_n", mul_clr_n, 1);
      chk("run_no_valid", out_valid, 0);
      if (k == 0 || k == N-1) begin
        chk("run_hold_i", mul_data_i, di);
        chk("run_hold_w", mul_data_w, dw);
      end
      if (k == abort_at) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_ready", in_ready, 1);
        return;
      end
      if (k == rst_at) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_count", out_count, 0);
        chk("rst_mul_i", mul_data_i, 0);
        chk("rst_mul_w", mul_data_w, 0);
        chk("rst_clr_n", mul_clr_n, 0);
        chk("rst_ready", in_ready, 1);
        for (int j = 0; j < N + 4; j++) begin
          step();
          if (j % 64 == 0) chk("rst_no_stale", out_valid, 0);
        end
        return;
      end
    end
    step();
    mul_bit = 1'b0;
    chk("done_valid", out_valid, 1);
    chk("done_count", out_count, sum);
    for (int h = 0; h < hold; h++) begin
      abort = (h % 2 == 0);
      step();
      chk("hold_valid", out_valid, 1);
      chk("hold_count", out_count, sum);
      chk("hold_ready", in_ready, 0);
    end
    abort = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_valid", out_valid, 0);
    chk("post_ready", in_ready, 1);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    int acc_at[$];
    int budget;
    rst_n = 1'b0; in_valid = 1'b0; abort = 1'b0; mul_bit = 1'b0; out_ready = 1'b0;
    in_data_i = '0; in_data_w = '0;
    step(); step();
    chk("reset_busy", busy, 0);
    chk("reset_valid", out_valid, 0);
    chk("reset_count", out_count, 0);
    chk("reset_mul_i", mul_data_i, 0);
    chk("reset_clr_n", mul_clr_n, 0);
    rst_n = 1'b1;
    chk("reset_ready", in_ready, 1);
    step();

    // Operands ignored while no handshake
    in_data_i = 15'h7fff; in_data_w = 15'h5555;
    step();
    chk("no_hs_i", mul_data_i, 0);
    chk("no_hs_w", mul_data_w, 0);

    run_job(15'h1234, 15'h0ABC, 0, -1, -1, 0);   // all ones -> N
    run_job(15'h0001, 15'h7FFF, 1, -1, -1, 0);   // all zeros -> 0
    run_job(15'h2222, 15'h3333, 2, -1, -1, 10);  // alternating -> N/2, stall + ignored abort
    run_job(15'h4444, 15'h5555, 0, 100, -1, 0);  // abort mid-run
    run_job(15'h0ABC, 15'h1234, 0, -1, -1, 0);   // no residue after abort
    run_job(15'h1111, 15'h2222, 0, N-1, -1, 0);  // abort on last run cycle beats DONE
    run_job(15'h6666, 15'h7777, 0, -1, 50, 0);   // reset mid-run
    for (int r = 0; r < 4; r++)
      run_job(15'($urandom), 15'($urandom), 3, -1, -1, int'($urandom_range(0, 3)));

    // in_valid and out_ready held high: accepts spaced N+3 apart
    in_valid = 1'b1; out_ready = 1'b1; mul_bit = 1'b1;
    budget = 0;
    while (acc_at.size() < 2 && budget < 3 * N) begin
      if (in_valid && in_ready) acc_at.push_back(cyc);
      step();
      budget++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_accepts", acc_at.size(), 2);
    if (acc_at.size() == 2) chk("b2b_spacing", acc_at[1] - acc_at[0], N + 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
